// File: rtl/sram_like_responder.sv
// SRAM-like bus responder: word-wide memory with byte enables and an in-order
// response queue of up to DEPTH outstanding transactions after a fixed latency.
module sram_like_responder #(
    parameter int ADDR_W  = 14,
    parameter int DEPTH   = 4,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req_i,
    input  logic        wr_i,
    input  logic [3:0]  wstrb_i,
    input  logic [31:0] addr_i,
    input  logic [2:0]  size_i,
    input  logic [31:0] wdata_i,
    input  logic        stall_i,
    output logic        addr_ok_o,
    output logic [31:0] rdata_o,
    output logic        data_ok_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [3:0] CD_LOAD = 4'(LATENCY - 1);

    logic [31:0]       mem_q [0:(1<<ADDR_W)-1];
    logic [31:0]       data_q [DEPTH];
    logic [3:0]        cd_q [DEPTH];
    logic [3:0]        cd_d [DEPTH];
    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [ADDR_W-1:0] widx;
    logic              accept;
    logic              pop;

    // Size and the ignored address bits are part of the bus but play no role here.
    logic unused_bits;
    assign unused_bits = ^{size_i, addr_i[1:0], addr_i[31:ADDR_W+2]};

    assign widx      = addr_i[ADDR_W+1:2];
    assign addr_ok_o = resetn && !stall_i && (count_q < CNT_W'(DEPTH));
    assign accept    = req_i && addr_ok_o;
    assign data_ok_o = resetn && (count_q != '0) && (cd_q[head_q] == 4'd0);
    assign pop       = data_ok_o;
    assign rdata_o   = data_ok_o ? data_q[head_q] : 32'd0;

    always_comb begin
        head_d  = head_q + PTR_W'(pop);
        tail_d  = tail_q + PTR_W'(accept);
        count_d = count_q + CNT_W'(accept) - CNT_W'(pop);
    end

    // Every slot counts down every cycle; a freshly pushed slot is reloaded instead.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_cd
        assign cd_d[gi] = (accept && (tail_q == PTR_W'(gi))) ? CD_LOAD :
                          (cd_q[gi] != 4'd0) ? cd_q[gi] - 4'd1 : 4'd0;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) cd_q[i] <= 4'd0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            for (int i = 0; i < DEPTH; i++) cd_q[i] <= cd_d[i];
        end
    end

    // Reads snapshot the word at acceptance; writes carry zero back as their response.
    always_ff @(posedge clk) begin
        if (accept) begin
            data_q[tail_q] <= wr_i ? 32'd0 : mem_q[widx];
        end
    end

    always_ff @(posedge clk) begin
        if (accept && wr_i) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb_i[b]) mem_q[widx][8*b +: 8] <= wdata_i[8*b +: 8];
            end
        end
    end

endmodule

// File: tb/tb_sram_like_responder.sv
// Directed bench for sram_like_responder: three instances (latency 2, 4 and 1)
// checked every cycle against a scoreboard of expected data and response cycle.
module tb_sram_like_responder;

    localparam int AW    = 8;
    localparam int DEPTH = 4;
    localparam int NI    = 3;
    localparam int LATS [NI] = '{2, 4, 1};

    typedef struct {
        logic [31:0] data;
        int          t;
    } exp_t;

    logic        clk = 1'b0;
    logic        resetn;
    logic        wr;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  size;
    logic        req     [NI];
    logic        stall   [NI];
    logic        addr_ok [NI];
    logic        data_ok [NI];
    logic [31:0] rdata   [NI];

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    for (genvar gi = 0; gi < NI; gi++) begin : g_inst
        exp_t        q[$];
        logic [31:0] model [int];
        int          last_t = 0;
        logic [31:0] last_rd = 32'd0;

        sram_like_responder #(
            .ADDR_W (AW),
            .DEPTH  (DEPTH),
            .LATENCY(LATS[gi])
        ) u_dut (
            .clk      (clk),
            .resetn   (resetn),
            .req_i    (req[gi]),
            .wr_i     (wr),
            .wstrb_i  (wstrb),
            .addr_i   (addr),
            .size_i   (size),
            .wdata_i  (wdata),
            .stall_i  (stall[gi]),
            .addr_ok_o(addr_ok[gi]),
            .rdata_o  (rdata[gi]),
            .data_ok_o(data_ok[gi])
        );

        // Sample mid-cycle: compare handshake outputs, then retire and enqueue.
        always @(negedge clk) begin
            exp_t        e;
            logic [31:0] d;
            int          idx;
            if (!resetn) begin
                check($sformatf("u%0d_rst_addr_ok", gi), 32'(addr_ok[gi]), 32'd0);
                check($sformatf("u%0d_rst_data_ok", gi), 32'(data_ok[gi]), 32'd0);
                check($sformatf("u%0d_rst_rdata", gi), rdata[gi], 32'd0);
                q.delete();
                last_t = 0;
            end else begin
                check($sformatf("u%0d_addr_ok@%0d", gi, cyc), 32'(addr_ok[gi]),
                      32'(!stall[gi] && (q.size() < DEPTH)));
                check($sformatf("u%0d_data_ok@%0d", gi, cyc), 32'(data_ok[gi]),
                      32'((q.size() > 0) && (q[0].t == cyc)));
                if (data_ok[gi] && (q.size() > 0)) begin
                    e = q.pop_front();
                    check($sformatf("u%0d_rdata@%0d", gi, cyc), rdata[gi], e.data);
                    last_rd = rdata[gi];
                end else begin
                    check($sformatf("u%0d_rdata_idle@%0d", gi, cyc), rdata[gi], 32'd0);
                end
                if (req[gi] && addr_ok[gi]) begin
                    idx = int'(addr[AW+1:2]);
                    d = model.exists(idx) ? model[idx] : 32'd0;
                    if (wr) begin
                        for (int b = 0; b < 4; b++)
                            if (wstrb[b]) d[8*b +: 8] = wdata[8*b +: 8];
                        model[idx] = d;
                        e.data = 32'd0;
                    end else begin
                        e.data = d;
                    end
                    e.t = (cyc + LATS[gi] > last_t + 1) ? cyc + LATS[gi] : last_t + 1;
                    last_t = e.t;
                    q.push_back(e);
                end
            end
        end
    end

    function automatic int pending(input int i);
        case (i)
            0:       return g_inst[0].q.size();
            1:       return g_inst[1].q.size();
            default: return g_inst[2].q.size();
        endcase
    endfunction

    function automatic logic [31:0] lastrd(input int i);
        case (i)
            0:       return g_inst[0].last_rd;
            1:       return g_inst[1].last_rd;
            default: return g_inst[2].last_rd;
        endcase
    endfunction

    task automatic issue(input int i, input logic w, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] s, output int tries);
        logic got;
        got   = 1'b0;
        tries = 0;
        wr = w; addr = a; wdata = d; wstrb = s;
        req[i] = 1'b1;
        while (!got && tries < 20) begin
            @(negedge clk);
            got = addr_ok[i];
            tries++;
            @(posedge clk); #1;
        end
        req[i] = 1'b0;
        $display("u%0d %s addr=%h wdata=%h wstrb=%h accepted=%0d after %0d cycle(s)",
                 i, w ? "WR" : "RD", a, d, s, got, tries);
        check($sformatf("u%0d_accept", i), 32'(got), 32'd1);
    endtask

    task automatic drain(input int i);
        for (int k = 0; k < 60 && pending(i) != 0; k++) begin
            @(posedge clk); #1;
        end
        check($sformatf("u%0d_drain", i), 32'(pending(i)), 32'd0);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        int t;
        resetn = 1'b0; wr = 1'b0; wstrb = 4'h0; addr = 32'd0; wdata = 32'd0; size = 3'd2;
        for (int i = 0; i < NI; i++) begin
            req[i]   = 1'b0;
            stall[i] = 1'b0;
        end
        idle(3);
        resetn = 1'b1;
        idle(2);

        // Write then read back-to-back on the latency-2 instance.
        issue(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, t);
        issue(0, 1'b0, 32'h10, 32'h0, 4'h0, t);
        drain(0);
        check("wr_rd_data", lastrd(0), 32'hDEADBEEF);

        // Partial byte strobes merge into the existing word.
        issue(0, 1'b1, 32'h40, 32'h11223344, 4'hF, t);
        issue(0, 1'b1, 32'h40, 32'hAABBCCDD, 4'b0101, t);
        issue(0, 1'b0, 32'h40, 32'h0, 4'h0, t);
        drain(0);
        check("strobe_merge", lastrd(0), 32'h11BB33DD);

        // Upper address bits alias and the byte offset is ignored.
        issue(0, 1'b1, 32'h483, 32'hCAFEF00D, 4'hF, t);
        issue(0, 1'b0, 32'h80, 32'h0, 4'h0, t);
        drain(0);
        check("alias_data", lastrd(0), 32'hCAFEF00D);

        // Stall holds off acceptance; release accepts in the same cycle.
        stall[0] = 1'b1; req[0] = 1'b1; wr = 1'b0; addr = 32'h10;
        repeat (3) begin
            @(negedge clk);
            check("stall_addr_ok", 32'(addr_ok[0]), 32'd0);
            @(posedge clk); #1;
        end
        stall[0] = 1'b0;
        @(negedge clk);
        check("stall_release", 32'(addr_ok[0]), 32'd1);
        @(posedge clk); #1;
        req[0] = 1'b0;
        drain(0);
        check("stall_read", lastrd(0), 32'hDEADBEEF);

        // Fill the latency-4 instance to DEPTH.
        for (int k = 0; k < 4; k++)
            issue(1, 1'b1, 32'h100 + 32'(4*k), 32'hA5000000 + 32'(k), 4'hF, t);
        drain(1);
        for (int k = 0; k < 4; k++) begin
            issue(1, 1'b0, 32'h100 + 32'(4*k), 32'h0, 4'h0, t);
            check("fill_no_wait", 32'(t), 32'd1);
        end
        @(negedge clk);
        check("fill_full", 32'(addr_ok[1]), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("fill_reopen", 32'(addr_ok[1]), 32'd1);
        drain(1);
        check("fill_last", lastrd(1), 32'hA5000003);

        // Reset with three reads in flight discards them; memory survives.
        for (int k = 0; k < 3; k++)
            issue(1, 1'b0, 32'h100 + 32'(4*k), 32'h0, 4'h0, t);
        resetn = 1'b0;
        idle(1);
        resetn = 1'b1;
        repeat (8) begin
            @(negedge clk);
            check("post_rst_data_ok", 32'(data_ok[1]), 32'd0);
            @(posedge clk); #1;
        end
        issue(1, 1'b0, 32'h104, 32'h0, 4'h0, t);
        drain(1);
        check("post_rst_mem", lastrd(1), 32'hA5000001);

        // Latency 1: one accept and one response every cycle.
        for (int k = 0; k < 8; k++)
            issue(2, 1'b1, 32'h200 + 32'(4*k), 32'h01010101 * 32'(k + 1), 4'hF, t);
        drain(2);
        for (int k = 0; k < 16; k++) begin
            issue(2, 1'b0, 32'h200 + 32'(4*(k % 8)), 32'h0, 4'h0, t);
            check("lat1_no_wait", 32'(t), 32'd1);
        end
        drain(2);
        check("lat1_last", lastrd(2), 32'h08080808);

        idle(4);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation time limit");
    end

endmodule
